vram_dma: RTL
=============

Name: vram_dma

Overview:
- Single-channel copy engine that fills the pixel-side VRAM32 contents from main memory.
- A CPU-facing register front end programs source, destination and length; the engine then streams 32-bit words into the VRAM32 write port.
- Optionally holds off until the frame synthesizer signals end of frame (frameDrawn), so tile and sprite tables change only during blanking.
- Sits directly upstream of the frame synthesizer's VRAM32/VRAM322 read ports, on the write side of those RAMs.

Parameters:
- SRC_W, 24, width of main-memory word address.
- DST_W, 14, width of VRAM32 word address; destination wraps modulo 2^DST_W.
- LEN_W, 14, width of transfer length in words.
- TIMEOUT, 255, max cycles waiting for mem_ack per word before aborting.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- cfg_src  in  SRC_W  source start word address, sampled on start.
- cfg_dst  in  DST_W  VRAM destination start address, sampled on start.
- cfg_len  in  LEN_W  number of words, sampled on start.
- cfg_vsync  in  1  1 = wait for end-of-frame before copying, sampled on start.
- start  in  1  one-cycle request pulse.
- frameDrawn  in  1  end-of-frame level from frame synthesizer (other clock domain, high ≥8 of its clocks).
- mem_addr  out  SRC_W  source read address.
- mem_req  out  1  read request.
- mem_ack  in  1  read data valid this cycle.
- mem_q  in  32  read data.
- vram_addr  out  DST_W  VRAM32 write address.
- vram_d  out  32  VRAM32 write data.
- vram_we  out  1  VRAM32 write strobe, one cycle per word.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky timeout flag; cleared by next accepted start.

Behaviour:
- Reset values: every output 0 (including vram_addr, vram_d, mem_addr); state IDLE; synchronizer flops 0.
- All outputs are registered.
- frameDrawn passes through a 2-flop synchronizer, then a rising-edge detector producing fd_rise (one clk pulse).
- States:
  - IDLE: busy=0. start latches src, dst, len and vsync into internal counters, clears error, and moves to WAITV if vsync=1, else READ. start while busy is ignored.
  - If the latched len=0: go to FIN immediately; no mem_req and no vram_we.
  - WAITV: busy=1; stays until fd_rise, then READ. An fd_rise in the same cycle as start is not used; wait for the next edge.
  - READ: mem_req=1, mem_addr=current src. When mem_ack=1 (may be the first cycle of READ), latch mem_q and go to WRITE; mem_req drops the next cycle.
    - A wait counter increments each READ cycle without ack. When it reaches TIMEOUT, set error=1 and go to FIN; remaining words are not written.
  - WRITE: vram_we=1 for exactly one cycle, with vram_addr=current dst and vram_d=latched word.
    - Then src+=1 (wraps at 2^SRC_W), dst+=1 (wraps at 2^DST_W), remaining-=1, wait counter cleared.
    - remaining reaching 0 → FIN, else READ.
  - FIN: done=1 for one cycle, busy=0 in the following cycle, return to IDLE. done also pulses on timeout.
- Timing:
  - busy rises the cycle after start is sampled.
  - Throughput is 2 cycles per word when ack is immediate.
  - With vsync=0 and immediate ack, first vram_we is at start+2 cycles and done is at start+2·len+1.
- mem_ack outside READ is ignored. vram_addr and vram_d hold their last values when vram_we=0.
- Reset asserted mid-transfer: immediate return to IDLE with all outputs 0. A partial VRAM write in progress is not completed.

Test Plan:
- Immediate transfer: reset, cfg_src=0x000100, cfg_dst=0x0010, cfg_len=4, cfg_vsync=0, start, mem_ack tied 1, mem_q=addr ^ 0xA5A5A5A5 → exactly 4 vram_we at addresses 0x0010..0x0013 with matching data; done 9 cycles after start; busy low the following cycle.
- Vsync hold: cfg_vsync=1, len=2, frameDrawn low 100 cycles → no mem_req and busy=1 throughout. Raise frameDrawn → first mem_req within 4 cycles of the synchronized edge; 2 writes; done.
- Destination wrap: cfg_dst=0x3FFE, len=4 → writes to 0x3FFE, 0x3FFF, 0x0000, 0x0001.
- Backpressure and timeout: ack delayed 5 cycles per word → data is correct and mem_req is held throughout each delay. Then ack never → error=1 and done pulse TIMEOUT+1 cycles after the READ entry; error clears on next start.
- Edge cases:
  - len=0 → done pulse, zero vram_we and zero mem_req.
  - start during busy → ignored, original transfer completes unchanged.
- Reset mid-transfer: reset asserted after the 2nd write of an 8-word copy → all outputs 0 the same cycle. A fresh start after release runs a full 8-word copy.

Source files
------------

// File: rtl/vram_dma.sv
// Single-channel copy engine: streams words from main memory into the VRAM32
// write port, optionally holding off until the frame synthesizer reports end of frame.
module vram_dma #(
  parameter int SRC_W   = 24,
  parameter int DST_W   = 14,
  parameter int LEN_W   = 14,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SRC_W-1:0] cfg_src,
  input  logic [DST_W-1:0] cfg_dst,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_vsync,
  input  logic             start,
  input  logic             frameDrawn,
  output logic [SRC_W-1:0] mem_addr,
  output logic             mem_req,
  input  logic             mem_ack,
  input  logic [31:0]      mem_q,
  output logic [DST_W-1:0] vram_addr,
  output logic [31:0]      vram_d,
  output logic             vram_we,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAITV,
    S_READ,
    S_WRITE,
    S_FIN
  } state_t;

  state_t             state;
  logic [DST_W-1:0]   dst_cnt;
  logic [LEN_W-1:0]   remaining;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               fd_meta;
  logic               fd_sync;
  logic               fd_prev;
  logic               fd_rise;

  // mem_addr doubles as the source counter; it only moves between words.
  assign fd_rise = fd_sync & ~fd_prev;

  // NOTE: every register, including the pass-through data regs, is cleared by
  // the async reset so no X reaches VRAM after a reset mid-transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      dst_cnt   <= '0;
      remaining <= '0;
      wait_cnt  <= '0;
      fd_meta   <= 1'b0;
      fd_sync   <= 1'b0;
      fd_prev   <= 1'b0;
      mem_addr  <= '0;
      mem_req   <= 1'b0;
      vram_addr <= '0;
      vram_d    <= '0;
      vram_we   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      // frameDrawn comes from the pixel clock domain; two flops before use.
      fd_meta <= frameDrawn;
      fd_sync <= fd_meta;
      fd_prev <= fd_sync;

      // NOTE: strobes default low here so each one lasts exactly one cycle;
      // the case arms below only ever raise them.
      done    <= 1'b0;
      vram_we <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            mem_addr  <= cfg_src;
            dst_cnt   <= cfg_dst;
            remaining <= cfg_len;
            wait_cnt  <= '0;
            error     <= 1'b0;
            busy      <= 1'b1;
            if (cfg_len == '0) begin
              done  <= 1'b1;
              state <= S_FIN;
            end else if (cfg_vsync) begin
              state <= S_WAITV;
            end else begin
              mem_req <= 1'b1;
              state   <= S_READ;
            end
          end
        end

        S_WAITV: begin
          if (fd_rise) begin
            mem_req <= 1'b1;
            state   <= S_READ;
          end
        end

        S_READ: begin
          if (mem_ack) begin
            vram_d    <= mem_q;
            vram_addr <= dst_cnt;
            vram_we   <= 1'b1;
            mem_req   <= 1'b0;
            state     <= S_WRITE;
          end else if (wait_cnt == WAIT_W'(TIMEOUT)) begin
            error   <= 1'b1;
            mem_req <= 1'b0;
            done    <= 1'b1;
            state   <= S_FIN;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        S_WRITE: begin
          mem_addr  <= mem_addr + SRC_W'(1);
          dst_cnt   <= dst_cnt + DST_W'(1);
          remaining <= remaining - LEN_W'(1);
          wait_cnt  <= '0;
          if (remaining == LEN_W'(1)) begin
            done  <= 1'b1;
            state <= S_FIN;
          end else begin
            mem_req <= 1'b1;
            state   <= S_READ;
          end
        end

        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
